// File: rtl/thermo_switch_decoder_pkg.sv
// Shared types, defaults and the thermometer-code decode helper for thermo_switch_decoder.
package thermo_switch_decoder_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_COMMIT = 2'd2
  } settle_state_t;

  localparam int DEF_WIDTH         = 8;
  localparam int DEF_STABLE_CYCLES = 10000;

  typedef struct packed {
    logic       legal;
    logic [3:0] level;
  } thermo_dec_t;

  // Callers zero-extend their vector to 15 bits; a legal code is k ones filled from bit 0.
  function automatic thermo_dec_t thermo_decode(input logic [14:0] vec);
    thermo_dec_t r;
    r = '0;
    for (int k = 0; k <= 15; k++) begin
      if ({1'b0, vec} == 16'((32'd1 << k) - 32'd1)) begin
        r.legal = 1'b1;
        r.level = 4'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/thermo_sync_settle.sv
// Two-flop synchroniser, polarity fix-up and whole-word debounce FSM.
// Emits the accepted vector on stable and a one-cycle commit strobe.
module thermo_sync_settle
  import thermo_switch_decoder_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int IS_PULLUP     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] stable,
  output logic             commit
);

  localparam int                 CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [WIDTH-1:0]   RAW_IDLE = (IS_PULLUP != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0] sync_p0, sync_p1, sync;
  logic [WIDTH-1:0] cand_q, cand_d, stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  settle_state_t    state_q, state_d;

  // Synchroniser stage: raw levels reset to the released-switch value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= RAW_IDLE;
      sync_p1 <= RAW_IDLE;
    end else begin
      sync_p0 <= sw_in;
      sync_p1 <= sync_p0;
    end
  end

  assign sync = (IS_PULLUP != 0) ? ~sync_p1 : sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // stable loads on entry to S_COMMIT so the top decodes it during the commit cycle
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    case (state_q)
      S_IDLE: begin
        if (sync != stable_q) begin
          cand_d  = sync;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (sync != cand_q) begin
          cand_d = sync;
          cnt_d  = '0;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = S_COMMIT;
            stable_d = cand_q;
          end
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign stable = stable_q;
  assign commit = (state_q == S_COMMIT);

endmodule

// File: rtl/thermo_switch_decoder.sv
// Debounced thermometer switch-bank reader: fill level, legality flag and buffered change events.
// Optional multi-step jump flag built only when THERMO_JUMP_DETECT_EN is defined.
module thermo_switch_decoder
  import thermo_switch_decoder_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int IS_PULLUP     = 1,
  localparam int LVL_W        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [LVL_W-1:0] level,
  output logic             thermo_err,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [LVL_W-1:0] evt_level,
  output logic             evt_up,
  output logic             evt_overrun,
  output logic             jump
);

  logic [WIDTH-1:0] stable;
  logic             commit;
  thermo_dec_t      dec;
  logic [LVL_W-1:0] new_lvl;
  logic             new_evt, accept;

  thermo_sync_settle #(
    .WIDTH        (WIDTH),
    .STABLE_CYCLES(STABLE_CYCLES),
    .IS_PULLUP    (IS_PULLUP)
  ) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_in (sw_in),
    .stable(stable),
    .commit(commit)
  );

  assign dec     = thermo_decode(15'(stable));
  assign new_lvl = LVL_W'(dec.level);
  assign new_evt = commit && dec.legal && (new_lvl != level);
  assign accept  = evt_valid && evt_ready;

  // Decode and single-entry event buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level       <= '0;
      thermo_err  <= 1'b0;
      evt_valid   <= 1'b0;
      evt_level   <= '0;
      evt_up      <= 1'b0;
      evt_overrun <= 1'b0;
    end else begin
      if (commit) thermo_err <= !dec.legal;
      if (new_evt) begin
        level     <= new_lvl;
        evt_valid <= 1'b1;
        evt_level <= new_lvl;
        evt_up    <= (new_lvl > level);
      end else if (accept) begin
        evt_valid <= 1'b0;
      end
      if (new_evt && evt_valid && !evt_ready) evt_overrun <= 1'b1;
      else if (accept)                        evt_overrun <= 1'b0;
    end
  end

`ifdef THERMO_JUMP_DETECT_EN
  logic             jump_q;
  logic [LVL_W-1:0] step;

  assign step = (new_lvl > level) ? (new_lvl - level) : (level - new_lvl);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       jump_q <= 1'b0;
    else if (new_evt) jump_q <= (step > LVL_W'(1));
  end

  assign jump = jump_q;
`else
  assign jump = 1'b0;
`endif

endmodule
